// File: rtl/modular_pkg.sv
// -----------------------------------------------------------------------------
// modular_pkg
// Shared definitions for the modular_n start/abort counter block:
//   - channel FSM state encodings and the enum built on them
//   - channel-count limit
//   - helper that ORs a vector while masking out one position
// -----------------------------------------------------------------------------
package modular_pkg;

   localparam logic [1:0] ENC_IDLE   = 2'd0;
   localparam logic [1:0] ENC_RUN    = 2'd1;
   localparam logic [1:0] ENC_DONE   = 2'd2;
   localparam logic [1:0] ENC_KILLED = 2'd3;

   localparam int unsigned MAX_CHANNELS = 16;

   typedef enum logic [1:0] {
      S_IDLE   = ENC_IDLE,
      S_RUN    = ENC_RUN,
      S_DONE   = ENC_DONE,
      S_KILLED = ENC_KILLED
   } chan_state_e;

   // True when any bit of vec other than position idx is set.
   function automatic logic others_any(input logic [MAX_CHANNELS-1:0] vec,
                                       input logic [3:0]              idx);
      logic [MAX_CHANNELS-1:0] mask;
      mask      = {MAX_CHANNELS{1'b1}};
      mask[idx] = 1'b0;
      return |(vec & mask);
   endfunction

endpackage

// File: rtl/modular_chan.sv
// -----------------------------------------------------------------------------
// modular_chan
// One start/abort counter channel: FSM, counter and latched reload mode.
// Ports:
//   clk, reset       clock and asynchronous active-low reset
//   go_i             start request (level)
//   kill_i           abort request (level)
//   auto_reload_i    mode, captured on start (1 = wrap and repeat)
//   kill_clr_i       releases the KILLED state
//   inhibit_i        blocks a new start while any kill is latched
//   abort_in         forced return to IDLE from another channel's kill
//   count_o          current count
//   done_o           completion (level in DONE, one-cycle pulse on wrap)
//   busy_o           channel in RUN
//   kill_src_o       channel in KILLED
//   run_kill         kill seen while running; feeds sibling aborts
// -----------------------------------------------------------------------------
module modular_chan
   import modular_pkg::*;
#(
   parameter int unsigned CNT_W    = 7,
   parameter int unsigned TERM_CNT = 100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go_i,
   input  logic             kill_i,
   input  logic             auto_reload_i,
   input  logic             kill_clr_i,
   input  logic             inhibit_i,
   input  logic             abort_in,
   output logic [CNT_W-1:0] count_o,
   output logic             done_o,
   output logic             busy_o,
   output logic             kill_src_o,
   output logic             run_kill
);

   localparam logic [CNT_W-1:0] TERM    = CNT_W'(TERM_CNT);
   localparam logic [CNT_W-1:0] TERM_M1 = CNT_W'(TERM_CNT - 1);
   localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   chan_state_e      state_q;
   logic [CNT_W-1:0] count_q;
   logic             done_q;
   logic             reload_q;

   // Channel FSM with counter, done flag and mode latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         count_q  <= ZERO;
         done_q   <= 1'b0;
         reload_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               count_q <= ZERO;
               done_q  <= 1'b0;
               // kill_i is deliberately not looked at here
               if (go_i && !inhibit_i) begin
                  state_q  <= S_RUN;
                  reload_q <= auto_reload_i;
               end
            end
            S_RUN: begin
               // Own kill outranks both a sibling abort and terminal count
               if (kill_i) begin
                  state_q <= S_KILLED;
                  done_q  <= 1'b0;
               end else if (abort_in) begin
                  state_q <= S_IDLE;
                  count_q <= ZERO;
                  done_q  <= 1'b0;
               end else if (count_q == TERM_M1) begin
                  done_q <= 1'b1;
                  if (reload_q) begin
                     count_q <= ZERO;
                  end else begin
                     count_q <= TERM;
                     state_q <= S_DONE;
                  end
               end else begin
                  count_q <= count_q + ONE;
                  done_q  <= 1'b0;
               end
            end
            S_DONE: begin
               if (!go_i) begin
                  state_q <= S_IDLE;
                  count_q <= ZERO;
                  done_q  <= 1'b0;
               end else begin
                  done_q <= 1'b1;
               end
            end
            S_KILLED: begin
               // A kill still asserted keeps the channel latched
               if (kill_clr_i && !kill_i) begin
                  state_q <= S_IDLE;
                  count_q <= ZERO;
               end
               done_q <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               count_q <= ZERO;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign count_o    = count_q;
   assign done_o     = done_q;
   assign busy_o     = (state_q == S_RUN);
   assign kill_src_o = (state_q == S_KILLED);
   assign run_kill   = (state_q == S_RUN) && kill_i;

endmodule

// File: rtl/modular_n.sv
// -----------------------------------------------------------------------------
// modular_n
// CHANNELS independent start/abort counters with a shared kill latch.
// Ports:
//   clk, reset    clock and asynchronous active-low reset
//   go            per-channel start request
//   kill          per-channel abort
//   auto_reload   per-channel mode, captured at start
//   kill_clr      clears latched kills
//   count         flattened counts, channel i at [i*CNT_W +: CNT_W]
//   done          per-channel completion
//   busy          per-channel RUN indication
//   kill_src      per-channel KILLED indication
//   kill_ltchd    any channel killed; also inhibits new starts
// -----------------------------------------------------------------------------
module modular_n
   import modular_pkg::*;
#(
   parameter int unsigned CHANNELS = 3,
   parameter int unsigned CNT_W    = 7,
   parameter int unsigned TERM_CNT = 100,
   parameter int unsigned KILL_ALL = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       go,
   input  logic [CHANNELS-1:0]       kill,
   input  logic [CHANNELS-1:0]       auto_reload,
   input  logic                      kill_clr,
   output logic [CHANNELS*CNT_W-1:0] count,
   output logic [CHANNELS-1:0]       done,
   output logic [CHANNELS-1:0]       busy,
   output logic [CHANNELS-1:0]       kill_src,
   output logic                      kill_ltchd
);

   if (TERM_CNT < 2 || TERM_CNT > (1 << CNT_W) - 1) begin : g_bad_term
      $error("modular_n: TERM_CNT outside 2 .. 2**CNT_W-1");
   end
   if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_chan
      $error("modular_n: CHANNELS outside 1 .. 16");
   end

   logic [CHANNELS-1:0]     run_kill_s;
   logic [CHANNELS-1:0]     abort_s;
   logic [MAX_CHANNELS-1:0] run_kill_ext_s;

   // Latched state only, so the start inhibit cannot be bypassed by kill_clr
   assign kill_ltchd     = |kill_src;
   assign run_kill_ext_s = MAX_CHANNELS'(run_kill_s);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      assign abort_s[i] = (KILL_ALL != 0) && others_any(run_kill_ext_s, 4'(i));

      modular_chan #(
         .CNT_W    (CNT_W),
         .TERM_CNT (TERM_CNT)
      ) u_chan (
         .clk           (clk),
         .reset         (reset),
         .go_i          (go[i]),
         .kill_i        (kill[i]),
         .auto_reload_i (auto_reload[i]),
         .kill_clr_i    (kill_clr),
         .inhibit_i     (kill_ltchd),
         .abort_in      (abort_s[i]),
         .count_o       (count[i*CNT_W +: CNT_W]),
         .done_o        (done[i]),
         .busy_o        (busy[i]),
         .kill_src_o    (kill_src[i]),
         .run_kill      (run_kill_s[i])
      );
   end

endmodule

// File: tb/tb_modular_n.sv
// -----------------------------------------------------------------------------
// tb_modular_n
// Scoreboard bench for modular_n: one instance with KILL_ALL=0 and one with
// KILL_ALL=1, both CHANNELS=3, CNT_W=7, TERM_CNT=10. Expected values are
// queued with the cycle they must appear on and compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_modular_n;

   localparam int CH = 3;
   localparam int W  = 7;
   localparam int TC = 10;

   // observable selectors; +8 addresses the KILL_ALL instance
   localparam int S_CNT0 = 0, S_CNT1 = 1, S_CNT2 = 2, S_DONE = 3;
   localparam int S_BUSY = 4, S_KSRC = 5, S_LTCH = 6, K = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [CH-1:0]     go, kill, ar;
   logic              kill_clr;
   logic [CH*W-1:0]   count;
   logic [CH-1:0]     done, busy, kill_src;
   logic              kill_ltchd;

   logic [CH-1:0]     go_k, kill_k, ar_k;
   logic              kill_clr_k;
   logic [CH*W-1:0]   count_k;
   logic [CH-1:0]     done_k, busy_k, kill_src_k;
   logic              kill_ltchd_k;

   modular_n #(.CHANNELS(CH), .CNT_W(W), .TERM_CNT(TC), .KILL_ALL(0)) dut (
      .clk(clk), .reset(reset), .go(go), .kill(kill), .auto_reload(ar),
      .kill_clr(kill_clr), .count(count), .done(done), .busy(busy),
      .kill_src(kill_src), .kill_ltchd(kill_ltchd));

   modular_n #(.CHANNELS(CH), .CNT_W(W), .TERM_CNT(TC), .KILL_ALL(1)) dut_ka (
      .clk(clk), .reset(reset), .go(go_k), .kill(kill_k), .auto_reload(ar_k),
      .kill_clr(kill_clr_k), .count(count_k), .done(done_k), .busy(busy_k),
      .kill_src(kill_src_k), .kill_ltchd(kill_ltchd_k));

   int cyc   = 0;
   int n_cmp = 0;
   int n_mis = 0;

   typedef struct {
      int          cyc;
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;
   exp_t sb_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] obs(input int sel);
      logic [31:0] v;
      v = 32'd0;
      case (sel)
         S_CNT0, S_CNT1, S_CNT2: v = 32'(count[sel*W +: W]);
         S_DONE:                 v = 32'(done);
         S_BUSY:                 v = 32'(busy);
         S_KSRC:                 v = 32'(kill_src);
         S_LTCH:                 v = 32'(kill_ltchd);
         K+S_CNT0, K+S_CNT1, K+S_CNT2: v = 32'(count_k[(sel-K)*W +: W]);
         K+S_DONE:               v = 32'(done_k);
         K+S_BUSY:               v = 32'(busy_k);
         K+S_KSRC:               v = 32'(kill_src_k);
         K+S_LTCH:               v = 32'(kill_ltchd_k);
         default:                v = 32'hDEAD_BEEF;
      endcase
      return v;
   endfunction

   task automatic expect_at(input int dc, input string tag, input int sel, input logic [31:0] v);
      exp_t e;
      e.cyc = cyc + dc;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      for (int s = 0; s < 7; s++) begin
         check_val($sformatf("%s_a%0d", tag, s), obs(s), 32'd0);
         check_val($sformatf("%s_k%0d", tag, s), obs(K + s), 32'd0);
      end
   endtask

   // Scoreboard: pop every entry whose cycle has been reached
   always @(negedge clk) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc <= cyc) begin
            check_val(sb_q[i].tag, obs(sb_q[i].sel), sb_q[i].exp);
            sb_q.delete(i);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; go = '0; kill = '0; ar = '0; kill_clr = 1'b0;
      go_k = '0; kill_k = '0; ar_k = '0; kill_clr_k = 1'b0;
      #2;
      check_all_zero("rst");
      @(negedge clk);
      reset = 1'b1;

      // one-shot run to terminal count, then release go
      tick(); go = 3'b001;
      expect_at(1,  "t1_busy",   S_BUSY, 32'd1);
      expect_at(1,  "t1_cnt0",   S_CNT0, 32'd0);
      expect_at(5,  "t1_cnt4",   S_CNT0, 32'd4);
      expect_at(10, "t1_cnt9",   S_CNT0, 32'd9);
      expect_at(10, "t1_nodone", S_DONE, 32'd0);
      expect_at(11, "t1_cnt10",  S_CNT0, 32'd10);
      expect_at(11, "t1_done",   S_DONE, 32'd1);
      expect_at(11, "t1_nobusy", S_BUSY, 32'd0);
      repeat (11) tick();
      go = 3'b000;
      expect_at(1, "t1_cnt_clr",  S_CNT0, 32'd0);
      expect_at(1, "t1_done_clr", S_DONE, 32'd0);
      tick(); tick();

      // kill at count 4, start inhibited, then kill_clr
      tick(); go = 3'b010;
      expect_at(5, "t2_cnt4", S_CNT1, 32'd4);
      repeat (5) tick();
      kill = 3'b010; go = 3'b000;
      expect_at(1, "t2_hold",  S_CNT1, 32'd4);
      expect_at(1, "t2_ksrc",  S_KSRC, 32'd2);
      expect_at(1, "t2_ltch",  S_LTCH, 32'd1);
      expect_at(1, "t2_busy",  S_BUSY, 32'd0);
      expect_at(3, "t2_hold2", S_CNT1, 32'd4);
      tick(); kill = 3'b000; go = 3'b100;
      expect_at(1, "t2_nostart",  S_BUSY, 32'd0);
      expect_at(2, "t2_nostart2", S_BUSY, 32'd0);
      tick(); tick();
      kill_clr = 1'b1;
      expect_at(1, "t2_clr_ltch", S_LTCH, 32'd0);
      expect_at(1, "t2_clr_cnt1", S_CNT1, 32'd0);
      expect_at(1, "t2_clr_busy", S_BUSY, 32'd0);
      tick(); kill_clr = 1'b0;
      expect_at(1, "t2_start2", S_BUSY, 32'd4);
      tick(); go = 3'b000;
      expect_at(1,  "t2_cnt2",   S_CNT2, 32'd1);
      expect_at(10, "t2_done2",  S_DONE, 32'd4);
      expect_at(10, "t2_term2",  S_CNT2, 32'd10);
      expect_at(11, "t2_idle2",  S_CNT2, 32'd0);
      repeat (12) tick();

      // auto-reload for 35 cycles
      tick(); go = 3'b001; ar = 3'b001;
      for (int k = 10; k <= 30; k += 10) begin
         expect_at(k,     $sformatf("t3_pre%0d", k),   S_DONE, 32'd0);
         expect_at(k + 1, $sformatf("t3_pulse%0d", k), S_DONE, 32'd1);
         expect_at(k + 2, $sformatf("t3_post%0d", k),  S_DONE, 32'd0);
      end
      expect_at(10, "t3_cnt9",  S_CNT0, 32'd9);
      expect_at(11, "t3_wrap",  S_CNT0, 32'd0);
      expect_at(12, "t3_cnt1",  S_CNT0, 32'd1);
      expect_at(31, "t3_wrap3", S_CNT0, 32'd0);
      expect_at(31, "t3_busy",  S_BUSY, 32'd1);
      repeat (35) tick();
      go = 3'b000; ar = 3'b000; kill = 3'b001;
      expect_at(1, "t3_kcnt", S_CNT0, 32'd4);
      expect_at(1, "t3_ksrc", S_KSRC, 32'd1);
      tick(); kill = 3'b000; kill_clr = 1'b1;
      expect_at(1, "t3_clr",     S_CNT0, 32'd0);
      expect_at(1, "t3_clrbusy", S_BUSY, 32'd0);
      tick(); kill_clr = 1'b0;
      tick();

      // kill at count 9 beats terminal count; kill beats kill_clr
      tick(); go = 3'b001;
      repeat (10) tick();
      kill = 3'b001; go = 3'b000;
      expect_at(1, "t4_cnt9",    S_CNT0, 32'd9);
      expect_at(1, "t4_nodone",  S_DONE, 32'd0);
      expect_at(1, "t4_ksrc",    S_KSRC, 32'd1);
      expect_at(2, "t4_nodone2", S_DONE, 32'd0);
      tick(); kill_clr = 1'b1;
      expect_at(1, "t4_keep",    S_LTCH, 32'd1);
      expect_at(1, "t4_keepcnt", S_CNT0, 32'd9);
      tick(); kill = 3'b000;
      expect_at(1, "t4_clr",     S_LTCH, 32'd0);
      expect_at(1, "t4_clrcnt",  S_CNT0, 32'd0);
      tick(); kill_clr = 1'b0;
      tick();

      // KILL_ALL instance: kill[0] aborts the other running channels
      tick(); go_k = 3'b111;
      expect_at(4, "t5_run", K + S_BUSY, 32'd7);
      repeat (4) tick();
      go_k = 3'b000; kill_k = 3'b001;
      expect_at(1, "t5_cnt0",  K + S_CNT0, 32'd3);
      expect_at(1, "t5_cnt1",  K + S_CNT1, 32'd0);
      expect_at(1, "t5_cnt2",  K + S_CNT2, 32'd0);
      expect_at(1, "t5_ksrc",  K + S_KSRC, 32'd1);
      expect_at(1, "t5_busy",  K + S_BUSY, 32'd0);
      expect_at(1, "t5_ltch",  K + S_LTCH, 32'd1);
      expect_at(2, "t5_busy2", K + S_BUSY, 32'd0);
      tick(); kill_k = 3'b000; kill_clr_k = 1'b1;
      expect_at(1, "t5_clr", K + S_LTCH, 32'd0);
      tick(); kill_clr_k = 1'b0;
      tick(); tick();

      // asynchronous reset in the middle of a run
      tick(); go = 3'b001;
      repeat (6) tick();
      check_val("t6_pre", obs(S_CNT0), 32'd5);
      reset = 1'b0;
      #1;
      check_all_zero("t6_rst");
      go = 3'b000;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) tick();

      for (int i = 0; i < sb_q.size(); i++) begin
         n_cmp++;
         n_mis++;
         $display("FAIL %s: never compared (due cycle %0d)", sb_q[i].tag, sb_q[i].cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
